ecall_io_sequencer: RTL and testbench
=====================================

Name: ecall_io_sequencer

Overview:
- Sits between the board inputs (confirm button, 16 switches, 3 test-case switches) and the core's ecall path (instruction fetch stall, register-file I/O port).
- Synchronizes and debounces the confirm button.
- When the core halts on an ecall, it lights the prompt LED for that ecall type, waits for one debounced press, captures the switch values, and issues a one-cycle continue pulse that releases the fetch stage.
- The exit ecall latches a terminal state.

Parameters:
- DEBOUNCE_CYCLES, 230000: consecutive stable synchronized samples required before the debounced level changes (10 ms at 23 MHz).
- SYNC_STAGES, 2: flip-flop stages in the button synchronizer; minimum 2.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ecall_req  in  1  high while the core is stalled on an ecall; held until continue is seen
- ecall_type  in  2  00 read switch input, 01 read test case, 10 display output, 11 exit; valid while ecall_req is high
- button_raw  in  1  asynchronous confirm button, active-high
- switch_raw  in  16  switch inputs
- test_raw  in  3  test-case switches
- continue_pulse  out  1  one-cycle release to the fetch stage
- io_value  out  32  captured value: {16'h0, switches} or {29'h0, test}
- io_write  out  1  one-cycle strobe coincident with continue_pulse for types 00 and 01; register file writes io_value to a0
- prompt_input_led  out  1  high while waiting for a press on type 00
- prompt_case_led  out  1  high while waiting for a press on type 01
- exit_led  out  1  high after an exit ecall
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, active-high) clears everything in the same edge:
  - state becomes IDLE;
  - all outputs go to 0 and io_value to 32'h0;
  - synchronizer flops, debounce counter and debounced level go to 0.
- Reset asserted in any state, including EXITED or mid-debounce, has this same effect.
- Synchronizer: button_raw passes through SYNC_STAGES flops to give btn_s.
- Debounce:
  - db_level is registered.
  - The counter increments each cycle that btn_s differs from db_level and clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, db_level toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
  - press is a single-cycle registered pulse on the 0-to-1 transition of db_level.
- States: IDLE, WAIT_PRESS, DRAIN, EXITED.
- IDLE:
  - ecall_req=1 with type 11 goes to EXITED.
  - ecall_req=1 with any other type goes to WAIT_PRESS and latches the type into cur_type.
  - A press in IDLE is discarded; there is no queuing.
- WAIT_PRESS:
  - prompt_input_led = (cur_type==00); prompt_case_led = (cur_type==01). For type 10 (display) neither prompt is lit; the press only acknowledges the displayed value.
  - On press: the next edge asserts continue_pulse for exactly one cycle.
  - On that same edge, for types 00 and 01, io_value is loaded from the switches sampled in the press cycle and io_write is asserted for one cycle. For type 10, io_value holds its previous value and io_write stays 0.
  - Prompt LEDs drop on the same edge. State goes to DRAIN.
  - Latency: press cycle N gives continue_pulse at cycle N+1.
  - If the button is already held (db_level=1) on entry, a release followed by a new press is required.
  - If ecall_req drops before any press (core aborted), return to IDLE with no pulse.
- DRAIN: wait until ecall_req=0, then IDLE. This guarantees one continue per ecall even when the core holds ecall_req for one more cycle after the pulse.
- EXITED:
  - exit_led=1; continue_pulse is never issued.
  - Leaves only on reset; ecall_req and button are ignored.
- io_value persists between ecalls until overwritten.
- switch_raw and test_raw are quasi-static and are sampled directly without synchronization.
- busy = (state != IDLE).

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset: reset=1 for 2 cycles with the button held -> all outputs 0, state IDLE; after release, db_level=0 until 4 stable cycles have elapsed.
- Type 00: ecall_req=1, ecall_type=00, switch_raw=16'hA5C3, clean press -> prompt_input_led=1 until the pulse; continue_pulse and io_write high for exactly 1 cycle; io_value=32'h0000A5C3; press-to-pulse latency = 2 sync + 4 debounce + 1 edge + 1 cycles, checked exactly.
- Glitch rejection: in WAIT_PRESS, button pulses 1, 2 and 3 cycles wide -> no continue_pulse; a 6-cycle press -> one pulse only.
- Held button and type 01: button held high before ecall_req with type=01, test_raw=3'd5 -> no pulse until release then press; io_value=32'h00000005, prompt_case_led cleared on the pulse.
- Double-trigger guard and type 10: ecall_req held 3 cycles past the pulse and a second press during DRAIN -> a single continue_pulse, io_write=0 for type 10, io_value unchanged.
- Exit: ecall_type=11 -> exit_led=1 on the next edge; 10 later presses give no pulse; reset clears exit_led and returns to IDLE.

Source files
------------

// File: rtl/ecall_io_sequencer.sv
// rtl/ecall_io_sequencer.sv - ecall I/O handshake: button sync/debounce, prompt LEDs, switch capture, continue pulse
module ecall_io_sequencer #(
    parameter int DEBOUNCE_CYCLES = 230000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ecall_req,
    input  logic [1:0]  ecall_type,
    input  logic        button_raw,
    input  logic [15:0] switch_raw,
    input  logic [2:0]  test_raw,
    output logic        continue_pulse,
    output logic [31:0] io_value,
    output logic        io_write,
    output logic        prompt_input_led,
    output logic        prompt_case_led,
    output logic        exit_led,
    output logic        busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_PRESS = 2'd1;
    localparam logic [1:0] DRAIN      = 2'd2;
    localparam logic [1:0] EXITED     = 2'd3;

    localparam logic [1:0] T_SWITCH  = 2'b00;
    localparam logic [1:0] T_CASE    = 2'b01;
    localparam logic [1:0] T_EXIT    = 2'b11;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    logic [CW-1:0]          db_cnt;
    logic                   db_level;
    logic                   db_prev;
    logic                   press;
    logic [1:0]             state;
    logic [1:0]             cur_type;

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            db_cnt   <= '0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], button_raw};
            db_prev <= db_level;
            // press fires one edge after db_level rises
            press   <= db_level & ~db_prev;
            if (btn_s != db_level) begin
                if (db_cnt == CNT_MAX) begin
                    db_level <= ~db_level;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cur_type       <= 2'b00;
            continue_pulse <= 1'b0;
            io_write       <= 1'b0;
            io_value       <= 32'h0;
        end else begin
            continue_pulse <= 1'b0;
            io_write       <= 1'b0;
            case (state)
                IDLE: begin
                    if (ecall_req) begin
                        if (ecall_type == T_EXIT) begin
                            state <= EXITED;
                        end else begin
                            state    <= WAIT_PRESS;
                            cur_type <= ecall_type;
                        end
                    end
                end
                WAIT_PRESS: begin
                    // an aborted ecall returns silently, even if a press lands in the same cycle
                    if (!ecall_req) begin
                        state <= IDLE;
                    end else if (press) begin
                        continue_pulse <= 1'b1;
                        state          <= DRAIN;
                        if (cur_type == T_SWITCH) begin
                            io_value <= {16'h0, switch_raw};
                            io_write <= 1'b1;
                        end else if (cur_type == T_CASE) begin
                            io_value <= {29'h0, test_raw};
                            io_write <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!ecall_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= EXITED;
                end
            endcase
        end
    end

    assign prompt_input_led = (state == WAIT_PRESS) && (cur_type == T_SWITCH);
    assign prompt_case_led  = (state == WAIT_PRESS) && (cur_type == T_CASE);
    assign exit_led         = (state == EXITED);
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_ecall_io_sequencer.sv
// tb/tb_ecall_io_sequencer.sv - directed self-checking bench for ecall_io_sequencer
module tb_ecall_io_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ecall_req;
    logic [1:0]  ecall_type;
    logic        button_raw;
    logic [15:0] switch_raw;
    logic [2:0]  test_raw;
    logic        continue_pulse;
    logic [31:0] io_value;
    logic        io_write;
    logic        prompt_input_led;
    logic        prompt_case_led;
    logic        exit_led;
    logic        busy;

    int n_checks = 0;
    int n_errs   = 0;
    int pulse_cnt = 0;
    int pc0;
    int lat;
    logic found;

    ecall_io_sequencer #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset(reset),
        .ecall_req(ecall_req),
        .ecall_type(ecall_type),
        .button_raw(button_raw),
        .switch_raw(switch_raw),
        .test_raw(test_raw),
        .continue_pulse(continue_pulse),
        .io_value(io_value),
        .io_write(io_write),
        .prompt_input_led(prompt_input_led),
        .prompt_case_led(prompt_case_led),
        .exit_led(exit_led),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (continue_pulse) pulse_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the button high and counts edges until continue_pulse, bounded.
    task automatic press_until_pulse(input int budget, output int edges, output logic hit);
        hit = 1'b0;
        edges = 0;
        button_raw = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if (continue_pulse) begin
                hit = 1'b1;
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ecall_req = 1'b0;
        ecall_type = 2'b00;
        button_raw = 1'b1;
        switch_raw = 16'h0;
        test_raw = 3'd0;
        step(2);

        check_eq("rst_continue", {31'h0, continue_pulse}, 32'h0);
        check_eq("rst_io_value", io_value, 32'h0);
        check_eq("rst_io_write", {31'h0, io_write}, 32'h0);
        check_eq("rst_leds", {29'h0, prompt_input_led, prompt_case_led, exit_led}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);

        reset = 1'b0;
        step(5);
        check_eq("db_level_early", {31'h0, dut.db_level}, 32'h0);
        step(1);
        check_eq("db_level_set", {31'h0, dut.db_level}, 32'h1);
        button_raw = 1'b0;
        step(10);
        check_eq("idle_press_dropped", pulse_cnt, 0);
        check_eq("idle_busy", {31'h0, busy}, 32'h0);

        // Type 00: switch capture and exact latency
        switch_raw = 16'hA5C3;
        ecall_type = 2'b00;
        ecall_req = 1'b1;
        step(1);
        check_eq("t00_prompt_on", {31'h0, prompt_input_led}, 32'h1);
        check_eq("t00_case_off", {31'h0, prompt_case_led}, 32'h0);
        press_until_pulse(20, lat, found);
        check_eq("t00_found", {31'h0, found}, 32'h1);
        check_eq("t00_latency", lat, 8);
        check_eq("t00_io_write", {31'h0, io_write}, 32'h1);
        check_eq("t00_io_value", io_value, 32'h0000A5C3);
        check_eq("t00_prompt_off", {31'h0, prompt_input_led}, 32'h0);
        step(1);
        check_eq("t00_pulse_1cyc", {31'h0, continue_pulse}, 32'h0);
        check_eq("t00_write_1cyc", {31'h0, io_write}, 32'h0);
        button_raw = 1'b0;
        ecall_req = 1'b0;
        step(1);
        check_eq("t00_back_idle", {31'h0, busy}, 32'h0);
        step(8);

        // Glitch rejection
        switch_raw = 16'h1234;
        ecall_req = 1'b1;
        step(1);
        pc0 = pulse_cnt;
        for (int w = 1; w <= 3; w++) begin
            button_raw = 1'b1;
            step(w);
            button_raw = 1'b0;
            step(8);
        end
        check_eq("glitch_no_pulse", pulse_cnt - pc0, 0);
        check_eq("glitch_still_wait", {31'h0, prompt_input_led}, 32'h1);
        button_raw = 1'b1;
        step(6);
        button_raw = 1'b0;
        step(12);
        check_eq("press6_one_pulse", pulse_cnt - pc0, 1);
        check_eq("press6_io_value", io_value, 32'h00001234);
        ecall_req = 1'b0;
        step(1);

        // Held button before type 01
        button_raw = 1'b1;
        step(10);
        test_raw = 3'd5;
        ecall_type = 2'b01;
        ecall_req = 1'b1;
        step(1);
        check_eq("t01_prompt_on", {31'h0, prompt_case_led}, 32'h1);
        pc0 = pulse_cnt;
        step(10);
        button_raw = 1'b0;
        step(10);
        check_eq("t01_held_no_pulse", pulse_cnt - pc0, 0);
        press_until_pulse(20, lat, found);
        check_eq("t01_found", {31'h0, found}, 32'h1);
        check_eq("t01_latency", lat, 8);
        check_eq("t01_io_value", io_value, 32'h00000005);
        check_eq("t01_io_write", {31'h0, io_write}, 32'h1);
        check_eq("t01_prompt_off", {31'h0, prompt_case_led}, 32'h0);
        button_raw = 1'b0;
        ecall_req = 1'b0;
        step(10);

        // Type 10 display with double-trigger guard
        switch_raw = 16'hFFFF;
        ecall_type = 2'b10;
        ecall_req = 1'b1;
        step(1);
        check_eq("t10_no_prompts", {30'h0, prompt_input_led, prompt_case_led}, 32'h0);
        check_eq("t10_busy", {31'h0, busy}, 32'h1);
        pc0 = pulse_cnt;
        press_until_pulse(20, lat, found);
        check_eq("t10_found", {31'h0, found}, 32'h1);
        check_eq("t10_io_write", {31'h0, io_write}, 32'h0);
        check_eq("t10_io_value", io_value, 32'h00000005);
        step(3);
        check_eq("t10_drain_busy", {31'h0, busy}, 32'h1);
        button_raw = 1'b0;
        step(10);
        button_raw = 1'b1;
        step(10);
        button_raw = 1'b0;
        ecall_req = 1'b0;
        step(1);
        check_eq("t10_single_pulse", pulse_cnt - pc0, 1);
        check_eq("t10_idle", {31'h0, busy}, 32'h0);
        step(8);

        // Exit
        ecall_type = 2'b11;
        ecall_req = 1'b1;
        step(1);
        check_eq("exit_led_on", {31'h0, exit_led}, 32'h1);
        check_eq("exit_busy", {31'h0, busy}, 32'h1);
        ecall_req = 1'b0;
        pc0 = pulse_cnt;
        for (int k = 0; k < 10; k++) begin
            button_raw = 1'b1;
            step(7);
            button_raw = 1'b0;
            step(7);
        end
        check_eq("exit_no_pulse", pulse_cnt - pc0, 0);
        check_eq("exit_led_hold", {31'h0, exit_led}, 32'h1);
        reset = 1'b1;
        step(1);
        check_eq("exit_rst_led", {31'h0, exit_led}, 32'h0);
        check_eq("exit_rst_busy", {31'h0, busy}, 32'h0);
        check_eq("exit_rst_io_value", io_value, 32'h0);
        reset = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule
